// File: rtl/jtcontra_romarb_if.sv
// Slot-side and SDRAM-side read bus of the Contra ROM arbiter.
// slave is the arbiter's view, master is the view of whatever drives the slots
// and models the SDRAM controller.
interface jtcontra_romarb_if #(
  parameter int AW = 22
);
  logic [3:0]      slot_cs;
  logic [4*AW-1:0] slot_addr;
  logic [3:0]      slot_ok;
  logic [63:0]     slot_data;
  logic            sdram_req;
  logic [AW-1:0]   sdram_addr;
  logic            sdram_ack;
  logic            sdram_rdy;
  logic [15:0]     sdram_din;

  modport slave (
    input  slot_cs, slot_addr, sdram_ack, sdram_rdy, sdram_din,
    output slot_ok, slot_data, sdram_req, sdram_addr
  );

  modport master (
    output slot_cs, slot_addr, sdram_ack, sdram_rdy, sdram_din,
    input  slot_ok, slot_data, sdram_req, sdram_addr
  );
endinterface

// File: rtl/jtcontra_romarb.sv
// Four-slot SDRAM read arbiter with a one-word tag cache per slot.
// Slots: 0 main CPU, 1 sound CPU, 2 ADPCM, 3 gfx. Each grant adds the slot's
// region offset to form the SDRAM word address.
// Optional macro JTCONTRA_ROMARB_PRIO_EN: slot 0 always wins when pending,
// slots 1-3 share round-robin among themselves.

// One cache lane: tag/data/valid for a single slot.
module jtcontra_romarb_lane #(
  parameter int AW = 22
)(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  input  logic          flush,
  input  logic          fill,
  input  logic          fill_valid,
  input  logic [AW-1:0] fill_tag,
  input  logic [15:0]   fill_data,
  output logic          hit,
  output logic [15:0]   data
);
  logic          valid;
  logic [AW-1:0] tag;

  // Fill on data return; a download flush overrides any fill in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else begin
      if (fill) begin
        valid <= fill_valid;
        tag   <= fill_tag;
        data  <= fill_data;
      end
      if (flush) valid <= 1'b0;
    end
  end

  assign hit = cs & valid & (addr == tag);
endmodule

module jtcontra_romarb #(
  parameter int            AW   = 22,
  parameter logic [AW-1:0] OFF0 = '0,
  parameter logic [AW-1:0] OFF1 = 22'h20000,
  parameter logic [AW-1:0] OFF2 = 22'h28000,
  parameter logic [AW-1:0] OFF3 = 22'h40000
)(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               downloading,
  jtcontra_romarb_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, WAIT_ACK, WAIT_DATA} state_t;

  localparam logic [3:0][AW-1:0] OFFS = {OFF3, OFF2, OFF1, OFF0};

  state_t               st, st_nxt;
  logic [3:0][AW-1:0]   addr;
  logic [3:0][15:0]     data;
  logic [3:0]           hit, pend;
  logic [1:0]           ptr, ptr_nxt, gnt, gnt_nxt, sel, idx;
  logic [AW-1:0]        gaddr, gaddr_nxt, raddr, raddr_nxt;
  logic                 req, req_nxt, fpend, fpend_nxt, fill;

  assign addr = bus.slot_addr;
  assign pend = bus.slot_cs & ~hit & {4{~downloading}};

  generate
    for (genvar n = 0; n < 4; n++) begin : g_lane
      jtcontra_romarb_lane #(.AW(AW)) u_lane (
        .clk       (clk),
        .rst_n     (rst_n),
        .cs        (bus.slot_cs[n]),
        .addr      (addr[n]),
        .flush     (downloading),
        .fill      (fill && (gnt == 2'(n))),
        .fill_valid(~fpend),
        .fill_tag  (gaddr),
        .fill_data (bus.sdram_din),
        .hit       (hit[n]),
        .data      (data[n])
      );
    end
  endgenerate

  // Circular search starting after ptr; descending loop so the nearest pending slot wins.
  always_comb begin
    sel = ptr;
    idx = '0;
    for (int i = 4; i >= 1; i--) begin
      idx = ptr + 2'(i);
`ifdef JTCONTRA_ROMARB_PRIO_EN
      if (pend[idx] && idx != 2'd0) sel = idx;
`else
      if (pend[idx]) sel = idx;
`endif
    end
`ifdef JTCONTRA_ROMARB_PRIO_EN
    if (pend[0]) sel = 2'd0;
`endif
  end

  // State and transaction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st    <= IDLE;
      req   <= 1'b0;
      raddr <= '0;
      gaddr <= '0;
      gnt   <= '0;
      ptr   <= 2'd3;
      fpend <= 1'b0;
    end else begin
      st    <= st_nxt;
      req   <= req_nxt;
      raddr <= raddr_nxt;
      gaddr <= gaddr_nxt;
      gnt   <= gnt_nxt;
      ptr   <= ptr_nxt;
      fpend <= fpend_nxt;
    end
  end

  // Next-state: grant in IDLE, hold request until ack, fill on rdy.
  always_comb begin
    st_nxt    = st;
    req_nxt   = req;
    raddr_nxt = raddr;
    gaddr_nxt = gaddr;
    gnt_nxt   = gnt;
    ptr_nxt   = ptr;
    fpend_nxt = fpend;
    fill      = 1'b0;
    case (st)
      IDLE: begin
        fpend_nxt = 1'b0;
        if (|pend) begin
          gnt_nxt   = sel;
          gaddr_nxt = addr[sel];
          raddr_nxt = addr[sel] + OFFS[sel];
          req_nxt   = 1'b1;
`ifdef JTCONTRA_ROMARB_PRIO_EN
          if (sel != 2'd0) ptr_nxt = sel;
`else
          ptr_nxt   = sel;
`endif
          st_nxt    = WAIT_ACK;
        end
      end
      WAIT_ACK: begin
        fpend_nxt = fpend | downloading;
        if (bus.sdram_ack) begin
          req_nxt = 1'b0;
          if (bus.sdram_rdy) begin
            fill   = 1'b1;
            st_nxt = IDLE;
          end else begin
            st_nxt = WAIT_DATA;
          end
        end
      end
      WAIT_DATA: begin
        fpend_nxt = fpend | downloading;
        if (bus.sdram_rdy) begin
          fill   = 1'b1;
          st_nxt = IDLE;
        end
      end
      default: st_nxt = IDLE;
    endcase
  end

  assign bus.slot_ok    = hit;
  assign bus.slot_data  = data;
  assign bus.sdram_req  = req;
  assign bus.sdram_addr = raddr;
endmodule
